// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared constants and types for the video output path: sync decode match
// values, the nominal byte period in 14M cycles, the video byte type and the
// sync decode helpers used at ld194 load time.
// -----------------------------------------------------------------------------
package video_pkg;

   // h_count_i[6:2] value that marks horizontal sync (H 0x4C..0x4F)
   localparam logic [4:0] H_SYNC_MATCH = 5'b10011;
   // v_count_i (vertical counter bits [8:3]) value that marks vertical sync
   localparam logic [5:0] V_SYNC_MATCH = 6'h3C;
   // 14M cycles between consecutive ld194 strobes on an active line
   localparam int unsigned BYTE_PERIOD = 14;

   // One byte fetched from video RAM: [6:0] dots LSB first, [7] half-dot delay
   typedef logic [7:0] vbyte_t;

   // Horizontal sync window decode; only the upper five counter bits matter
   function automatic logic hsync_decode(input logic [4:0] h_hi);
      return (h_hi == H_SYNC_MATCH);
   endfunction

   // Vertical sync window decode: V 0x1E0..0x1E3 (bit 2 of the counter clear)
   function automatic logic vsync_decode(input logic [5:0] v_hi, input logic vc);
      return (v_hi == V_SYNC_MATCH) & ~vc;
   endfunction

endpackage

// File: rtl/hires_serializer.sv
// -----------------------------------------------------------------------------
// hires_serializer
// Holds the 7-bit dot shift register, the half-dot delay flag and a one-cycle
// delayed copy of the current dot. Produces the unregistered dot that the top
// level registers into pixel_o.
// Ports:
//   clock_14_i  in   14M master clock
//   reset_i     in   asynchronous active-high reset
//   clock_7_i   in   7M phase; a shift happens on edges where it is low
//   ld194_n_i   in   active-low load strobe (wins over shift)
//   data_i      in   video RAM byte
//   dot_o       out  selected dot (delayed or direct), optionally inverted
// -----------------------------------------------------------------------------
module hires_serializer
   import video_pkg::*;
#(
   parameter int unsigned HIRES_DELAY_EN = 1,
   parameter int unsigned PIXEL_INVERT   = 0
) (
   input  logic   clock_14_i,
   input  logic   reset_i,
   input  logic   clock_7_i,
   input  logic   ld194_n_i,
   input  vbyte_t data_i,
   output logic   dot_o
);

   localparam logic DELAY_EN = (HIRES_DELAY_EN != 0);
   localparam logic INVERT   = (PIXEL_INVERT != 0);

   logic [6:0] shreg_q;
   logic [6:0] shreg_d;
   logic       delay_q;
   logic       delay_d;
   // Previous cycle's shreg[0]; during a delayed byte this is what is shown,
   // so the first cycle of such a byte repeats the prior byte's last dot.
   logic       prev_dot_q;

   // Next-state: load overrides shift; shift only on the low 7M phase
   always_comb begin
      shreg_d = shreg_q;
      delay_d = delay_q;
      if (!ld194_n_i) begin
         shreg_d = data_i[6:0];
         delay_d = data_i[7] & DELAY_EN;
      end else if (!clock_7_i) begin
         shreg_d = {1'b0, shreg_q[6:1]};
      end else begin
         shreg_d = shreg_q;
      end
   end

   // Shift register, delay flag and delayed dot storage
   always_ff @(posedge clock_14_i or posedge reset_i) begin
      if (reset_i) begin
         shreg_q    <= 7'd0;
         delay_q    <= 1'b0;
         prev_dot_q <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         delay_q    <= delay_d;
         prev_dot_q <= shreg_q[0];
      end
   end

   // Dot select: delayed bytes show the one-cycle-old dot
   always_comb begin
      if (delay_q) begin
         dot_o = prev_dot_q ^ INVERT;
      end else begin
         dot_o = shreg_q[0] ^ INVERT;
      end
   end

endmodule

// File: rtl/video_shifter.sv
// -----------------------------------------------------------------------------
// video_shifter
// Receiving end of the video fetch timing. Serialises the RAM byte loaded at
// each ld194 strobe into a 14M mono hires pixel stream and aligns blanking and
// syncs with it.
// Ports:
//   clock_14_i  in   14M master clock
//   reset_i     in   asynchronous active-high reset
//   clock_7_i   in   7M phase, shift qualifier
//   ld194_n_i   in   active-low load strobe, one 14M cycle wide
//   data_i      in   video RAM byte (valid with the strobe)
//   blank_i     in   composite blanking for the byte being loaded
//   h_count_i   in   horizontal counter
//   v_count_i   in   vertical counter bits [8:3]
//   vc_i        in   vertical counter bit 2
//   pixel_o     out  serial pixel
//   blank_o     out  blanking aligned with pixel_o
//   hsync_o     out  horizontal sync, active high
//   vsync_o     out  vertical sync, active high
// -----------------------------------------------------------------------------
module video_shifter
   import video_pkg::*;
#(
   parameter int unsigned HIRES_DELAY_EN = 1,
   parameter int unsigned PIXEL_INVERT   = 0
) (
   input  logic       clock_14_i,
   input  logic       reset_i,
   input  logic       clock_7_i,
   input  logic       ld194_n_i,
   input  vbyte_t     data_i,
   input  logic       blank_i,
   input  logic [6:0] h_count_i,
   input  logic [5:0] v_count_i,
   input  logic       vc_i,
   output logic       pixel_o,
   output logic       blank_o,
   output logic       hsync_o,
   output logic       vsync_o
);

   logic dot_s;
   logic hs_s;
   logic vs_s;
   logic blank_q;
   logic blank_d;
   logic hs_q;
   logic hs_d;
   logic vs_q;
   logic vs_d;
   logic unused_h_lsb;

   // The two low horizontal bits do not take part in the sync window
   assign unused_h_lsb = ^h_count_i[1:0];

   hires_serializer #(
      .HIRES_DELAY_EN (HIRES_DELAY_EN),
      .PIXEL_INVERT   (PIXEL_INVERT)
   ) u_ser (
      .clock_14_i (clock_14_i),
      .reset_i    (reset_i),
      .clock_7_i  (clock_7_i),
      .ld194_n_i  (ld194_n_i),
      .data_i     (data_i),
      .dot_o      (dot_s)
   );

   // Sync decode of the counters presented with the strobe
   always_comb begin
      hs_s = hsync_decode(h_count_i[6:2]);
      vs_s = vsync_decode(v_count_i, vc_i);
   end

   // Byte attributes are captured only at load so they track the byte being shown
   always_comb begin
      blank_d = blank_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      if (!ld194_n_i) begin
         blank_d = blank_i;
         hs_d    = hs_s;
         vs_d    = vs_s;
      end else begin
         blank_d = blank_q;
         hs_d    = hs_q;
         vs_d    = vs_q;
      end
   end

   // Attribute capture and output registers
   always_ff @(posedge clock_14_i or posedge reset_i) begin
      if (reset_i) begin
         blank_q <= 1'b1;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         pixel_o <= 1'b0;
         blank_o <= 1'b1;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
      end else begin
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         // Blanking forces black regardless of inversion
         pixel_o <= blank_q ? 1'b0 : dot_s;
         blank_o <= blank_q;
         hsync_o <= hs_q;
         vsync_o <= vs_q;
      end
   end

endmodule

// File: tb/tb_video_shifter.sv
module tb_video_shifter;
   import video_pkg::*;

   // Steady 0x55 window, bit k = pixel after edge N+k (prev byte was 0x55)
   localparam logic [13:0] EXP55 = 14'b10011001100111;
   // 0xD5 following a byte whose last dot was 1
   localparam logic [13:0] EXPD5 = 14'b00110011001111;

   logic       clk = 1'b0;
   logic       rst;
   logic       c7;
   logic       ld_n;
   vbyte_t     data;
   logic       bl;
   logic [6:0] hc;
   logic [5:0] vcnt;
   logic       vcb;
   logic       pix, blk, hs, vs;
   logic       pix_i, blk_i, hs_i, vs_i;
   int         total = 0;
   int         bad = 0;
   logic [13:0] w_pix, w_inv, w_blk, w_hs, w_vs;

   always #5 clk = ~clk;

   video_shifter dut (
      .clock_14_i (clk), .reset_i (rst), .clock_7_i (c7), .ld194_n_i (ld_n),
      .data_i (data), .blank_i (bl), .h_count_i (hc), .v_count_i (vcnt), .vc_i (vcb),
      .pixel_o (pix), .blank_o (blk), .hsync_o (hs), .vsync_o (vs)
   );

   video_shifter #(.HIRES_DELAY_EN(0), .PIXEL_INVERT(1)) dut_inv (
      .clock_14_i (clk), .reset_i (rst), .clock_7_i (c7), .ld194_n_i (ld_n),
      .data_i (data), .blank_i (bl), .h_count_i (hc), .v_count_i (vcnt), .vc_i (vcb),
      .pixel_o (pix_i), .blank_o (blk_i), .hsync_o (hs_i), .vsync_o (vs_i)
   );

   task automatic cyc(input logic ld, input logic [7:0] d, input logic b,
                      input logic [6:0] h, input logic [5:0] v, input logic vb, input logic c);
      ld_n = ld; data = d; bl = b; hc = h; vcnt = v; vcb = vb; c7 = c;
      @(posedge clk);
      #1;
   endtask

   // One nominal byte period: load at k=0, shifts on even edges after it
   task automatic send(input logic [7:0] d, input logic b, input logic [6:0] h,
                       input logic [5:0] v, input logic vb);
      for (int k = 0; k < BYTE_PERIOD; k++) begin
         cyc((k == 0) ? 1'b0 : 1'b1, d, b, h, v, vb, k[0]);
         w_pix[k] = pix; w_inv[k] = pix_i; w_blk[k] = blk; w_hs[k] = hs; w_vs[k] = vs;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(1'b1, 8'h00, 1'b0, 7'h40, 6'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 7'h40, 6'h00, 1'b0, 1'b1);
      total++; if ({pix, blk, hs, vs} !== 4'b0100) begin bad++;
         $display("FAIL reset_outputs got=%b want=0100", {pix, blk, hs, vs}); end
      total++; if (pix_i !== 1'b0) begin bad++;
         $display("FAIL reset_inv_pixel got=%b want=0", pix_i); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'hFF, 1'b0, 7'h4C, 6'h3C, 1'b0, i[0]);
         total++; if ({pix, blk, hs, vs} !== 4'b0100) begin bad++;
            $display("FAIL reset_idle got=%b want=0100 cycle=%0d", {pix, blk, hs, vs}, i); end
      end
   endtask

   task automatic test_pattern_55();
      send(8'h55, 1'b0, 7'h40, 6'h00, 1'b0);
      total++; if (w_pix[13:1] !== EXP55[13:1]) begin bad++;
         $display("FAIL first_55 got=%b want=%b", w_pix[13:1], EXP55[13:1]); end
      total++; if (w_blk[13:1] !== 13'd0) begin bad++;
         $display("FAIL first_55_blank got=%b want=0", w_blk[13:1]); end
      for (int r = 0; r < 2; r++) begin
         send(8'h55, 1'b0, 7'h40, 6'h00, 1'b0);
         total++; if (w_pix !== EXP55) begin bad++;
            $display("FAIL steady_55 got=%b want=%b rep=%0d", w_pix, EXP55, r); end
         total++; if (w_inv !== ~EXP55) begin bad++;
            $display("FAIL steady_55_inv got=%b want=%b rep=%0d", w_inv, ~EXP55, r); end
         total++; if (w_blk !== 14'd0) begin bad++;
            $display("FAIL steady_55_blank got=%b want=0", w_blk); end
      end
   endtask

   task automatic test_delay();
      send(8'hD5, 1'b0, 7'h40, 6'h00, 1'b0);
      total++; if (w_pix !== EXPD5) begin bad++;
         $display("FAIL delayed_D5 got=%b want=%b", w_pix, EXPD5); end
      // Instance without delay treats 0xD5 like 0x55
      total++; if (w_inv !== ~EXP55) begin bad++;
         $display("FAIL nodelay_D5_inv got=%b want=%b", w_inv, ~EXP55); end
      send(8'h55, 1'b0, 7'h40, 6'h00, 1'b0);
      total++; if (w_pix !== EXP55) begin bad++;
         $display("FAIL after_D5 got=%b want=%b", w_pix, EXP55); end
   endtask

   task automatic test_blank();
      send(8'hFF, 1'b1, 7'h40, 6'h00, 1'b0);
      total++; if (w_pix !== 14'b00000000000001) begin bad++;
         $display("FAIL blank_pixel got=%b want=00000000000001", w_pix); end
      total++; if (w_inv !== 14'd0) begin bad++;
         $display("FAIL blank_inv_pixel got=%b want=0", w_inv); end
      total++; if (w_blk !== 14'b11111111111110) begin bad++;
         $display("FAIL blank_flag got=%b want=11111111111110", w_blk); end
      send(8'h55, 1'b0, 7'h40, 6'h00, 1'b0);
      total++; if ({w_pix[0], w_inv[0], w_blk[0]} !== 3'b001) begin bad++;
         $display("FAIL unblank_edge got=%b want=001", {w_pix[0], w_inv[0], w_blk[0]}); end
      total++; if (w_pix[13:1] !== EXP55[13:1]) begin bad++;
         $display("FAIL unblank_pixel got=%b want=%b", w_pix[13:1], EXP55[13:1]); end
   endtask

   task automatic test_hsync();
      logic [6:0] hl [7] = '{7'h4B, 7'h4C, 7'h4D, 7'h4E, 7'h4F, 7'h50, 7'h00};
      logic prev = 1'b0;
      logic cur;
      int   ones = 0;
      for (int i = 0; i < 7; i++) begin
         cur = (hl[i] >= 7'h4C) && (hl[i] <= 7'h4F);
         send(8'h00, 1'b0, hl[i], 6'h00, 1'b0);
         ones += $countones(w_hs);
         total++; if ({w_hs[13:1], w_hs[0]} !== {{13{cur}}, prev}) begin bad++;
            $display("FAIL hsync_window got=%b want=%b h=%h", w_hs, {{13{cur}}, prev}, hl[i]); end
         prev = cur;
      end
      total++; if (ones != 56) begin bad++;
         $display("FAIL hsync_length got=%0d want=56", ones); end
   endtask

   task automatic test_vsync();
      logic [5:0] vl [7] = '{6'h3B, 6'h3C, 6'h3C, 6'h3C, 6'h3C, 6'h3C, 6'h3D};
      logic       bl7 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic prev = 1'b0;
      logic cur;
      for (int i = 0; i < 7; i++) begin
         cur = (vl[i] == 6'h3C) && !bl7[i];
         send(8'h55, 1'b0, 7'h40, vl[i], bl7[i]);
         total++; if ({w_vs[13:1], w_vs[0]} !== {{13{cur}}, prev}) begin bad++;
            $display("FAIL vsync_window got=%b want=%b v=%h vc=%b", w_vs,
                     {{13{cur}}, prev}, vl[i], bl7[i]); end
         prev = cur;
      end
   endtask

   task automatic test_drain();
      cyc(1'b0, 8'h7F, 1'b0, 7'h40, 6'h00, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b1, 8'h00, 1'b0, 7'h40, 6'h00, 1'b0, k[0]);
         total++; if (pix !== ((k <= 14) ? 1'b1 : 1'b0)) begin bad++;
            $display("FAIL drain got=%b want=%b edge=N+%0d", pix, (k <= 14), k); end
      end
   endtask

   task automatic test_hold_low();
      logic [7:0] dl [8] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h7F, 8'h02};
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, dl[i], 1'b0, 7'h40, 6'h00, 1'b0, 1'b1);
         if (i > 0) begin
            total++; if (pix !== dl[i-1][0]) begin bad++;
               $display("FAIL hold_low got=%b want=%b i=%0d", pix, dl[i-1][0], i); end
         end
      end
   endtask

   task automatic test_reset_midline();
      cyc(1'b0, 8'h7F, 1'b0, 7'h4C, 6'h00, 1'b0, 1'b0);
      for (int k = 1; k < 5; k++) cyc(1'b1, 8'h7F, 1'b0, 7'h4C, 6'h00, 1'b0, k[0]);
      rst = 1'b1;
      #1;
      total++; if ({pix, blk, hs, vs} !== 4'b0100) begin bad++;
         $display("FAIL reset_midline_async got=%b want=0100", {pix, blk, hs, vs}); end
      cyc(1'b1, 8'h7F, 1'b0, 7'h4C, 6'h00, 1'b0, 1'b1);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 8'h7F, 1'b0, 7'h4C, 6'h3C, 1'b0, k[0]);
         total++; if ({pix, blk, hs, vs} !== 4'b0100) begin bad++;
            $display("FAIL reset_midline_hold got=%b want=0100 cycle=%0d", {pix, blk, hs, vs}, k); end
      end
      send(8'h55, 1'b0, 7'h40, 6'h00, 1'b0);
      total++; if (w_pix[13:1] !== EXP55[13:1]) begin bad++;
         $display("FAIL reset_first_byte got=%b want=%b", w_pix[13:1], EXP55[13:1]); end
   endtask

   initial begin
      rst = 1'b1; c7 = 1'b0; ld_n = 1'b1; data = 8'h00; bl = 1'b0;
      hc = 7'h40; vcnt = 6'h00; vcb = 1'b0;
      test_reset();
      test_pattern_55();
      test_delay();
      test_blank();
      test_hsync();
      test_vsync();
      test_drain();
      test_hold_low();
      test_reset_midline();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
